adder_pipe_arbiter: RTL and testbench
=====================================

// Module: adder_pipe_arbiter
// PURPOSE
//  Shares one adder_4bits_pipeline instance between two requesters.
//  Each cycle, a round-robin arbiter grants at most one request and drives that
//  requester's operands onto the adder. A tag shift register tracks each issued
//  operation through the adder pipeline and steers the {c,sum} result back to the
//  owner with a one-cycle valid strobe. A stop/drain FSM lets the system quiesce
//  the shared adder: no new grants, all in-flight results delivered.
// PARAMETERS
//  LATENCY   2   clock edges from operand capture to a stable {c,sum} at the adder output; must match adder
//  CNT_W     8   width of the per-requester completion counters
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      synchronous, active-low; also drives the adder's RST
//  stop       in   1      level; 1 = stop granting and drain the pipeline
//  req0       in   1      requester 0 has an operation; hold until gnt0
//  a0, b0     in   4      requester 0 operands; stable while req0=1
//  gnt0       out  1      combinational; operation 0 accepted this cycle
//  req1       in   1      requester 1 request
//  a1, b1     in   4      requester 1 operands
//  gnt1       out  1      combinational grant to requester 1
//  add_a      out  4      to adder a: a0/a1 of the granted requester, else 4'h0
//  add_b      out  4      to adder b: b0/b1 of the granted requester, else 4'h0
//  add_sum    in   4      from adder sum
//  add_c      in   1      from adder carry-out
//  vld0       out  1      result for requester 0 is on res0 this cycle
//  res0       out  5      {add_c, add_sum}; meaningful only when vld0=1
//  vld1, res1 out  1,5    same for requester 1
//  idle       out  1      1 = FSM in HALT (stopped, pipeline empty)
//  done0      out  CNT_W  count of vld0 strobes, wraps modulo 2^CNT_W
//  done1      out  CNT_W  count of vld1 strobes
// BEHAVIOUR
//  Reset (reset=0 at an edge): ptr=0; tag pipe valids=0; done0=done1=0;
//   FSM=RUN; idle=0. gnt0, gnt1, vld0 and vld1 are all 0 while reset=0.
//  FSM:
//   RUN   -> DRAIN when stop=1. In RUN, grants are issued.
//   DRAIN -> HALT when all tag valids are 0; -> RUN if stop=0. No grants.
//   HALT  -> RUN when stop=0. No grants; idle=1.
//   Grants depend on the registered state only. stop seen in cycle N blocks grants from N+1.
//  Arbitration (RUN only; at most one grant per cycle; gnt0 and gnt1 never both 1):
//   Only one requests -> grant it.
//   Both request -> grant the one selected by ptr (0 = req0 first).
//   ptr <= index of the non-granted requester after every grant; unchanged on an idle cycle.
//   Result: strict alternation under continuous contention.
//  Tag pipe: LATENCY-stage shift of {valid, id}. Stage 0 loads {grant_any, granted id} each edge.
//   Output stage drives: vld0 = v & (id==0); vld1 = v & (id==1).
//  Latency: grant in cycle N -> vldX=1 in cycle N+LATENCY, exactly one cycle.
//  res0 = res1 = {add_c, add_sum} (combinational pass-through, 5-bit unsigned, no overflow).
//  Back-to-back: one issue per cycle sustained; results return in grant order.
//  Reset mid-operation: in-flight tags are discarded; no vld for them after reset.
//  done0/done1 increment on vld0/vld1; 2^CNT_W-1 + 1 wraps to 0.
// TESTING
//  1. Only req0, a0=4'h9, b0=4'h8, LATENCY=2 -> gnt0 in cycle N; vld0=1, res0=5'h11 in cycle N+2; vld1 stays 0.
//  2. req0=req1=1 for 6 cycles after reset -> grants 0,1,0,1,0,1; results return in that order; done0=done1=3.
//  3. stop=1 with 2 ops in flight -> no grants from next cycle; both vlds delivered; idle=1 one cycle after last vld.
//     stop=0 -> grants resume next cycle.
//  4. reset=0 one cycle after a grant -> no vld for that op; done0=done1=0; ptr=0.
//  5. 256 consecutive req0 ops with a0=4'hF, b0=4'h1 -> every res0=5'h10; done0 wraps to 8'h00.

Source files
------------

// File: rtl/adder_pipe_arbiter.sv
// ---------------------------------------------------------------------------
// adder_pipe_arbiter
//
// Shares one external pipelined 4-bit adder between two requesters. A
// round-robin arbiter grants at most one request per cycle and drives the
// winner's operands onto the adder. A {valid,id} tag shift register follows
// every issued operation through the adder pipeline and raises a one-cycle
// result strobe for its owner. A RUN/DRAIN/HALT FSM lets the system stop
// granting and wait until every in-flight result has been delivered.
//
// Handshake: a requester raises i_reqX with stable operands and holds both
// until it sees o_gntX=1 in the same cycle; the operation is accepted in
// that cycle. o_vldX is a strobe with no back-pressure: the result on
// o_resX is valid only in the single cycle o_vldX=1.
//
// Ports
//   clk, reset      clock (rising edge), synchronous active-low reset; reset
//                   also drives the adder's RST outside this block
//   i_stop          level; 1 = stop granting and drain the pipeline
//   i_req0/1        requests; i_a0/i_b0, i_a1/i_b1 operands
//   o_gnt0/1        combinational grants (never both 1)
//   o_add_a/b       operands to the adder (4'h0 when nothing is granted)
//   i_add_sum/c     adder result
//   o_vld0/1        result strobes; o_res0/1 = {i_add_c, i_add_sum}
//   o_idle          FSM is in HALT (stopped, pipeline empty)
//   o_done0/1       completion counters, wrap modulo 2^CNT_W
//   o_state         current FSM state for debug/checkers
// ---------------------------------------------------------------------------
module adder_pipe_arbiter #(
    parameter int LATENCY = 2,   // edges from operand capture to stable adder output (>= 2)
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_stop,
    input  logic             i_req0,
    input  logic [3:0]       i_a0,
    input  logic [3:0]       i_b0,
    output logic             o_gnt0,
    input  logic             i_req1,
    input  logic [3:0]       i_a1,
    input  logic [3:0]       i_b1,
    output logic             o_gnt1,
    output logic [3:0]       o_add_a,
    output logic [3:0]       o_add_b,
    input  logic [3:0]       i_add_sum,
    input  logic             i_add_c,
    output logic             o_vld0,
    output logic [4:0]       o_res0,
    output logic             o_vld1,
    output logic [4:0]       o_res1,
    output logic             o_idle,
    output logic [CNT_W-1:0] o_done0,
    output logic [CNT_W-1:0] o_done1,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ptr;        // 0 = requester 0 wins a tie, 1 = requester 1
    logic [LATENCY-1:0] r_tag_v;
    logic [LATENCY-1:0] r_tag_id;
    logic [CNT_W-1:0]   r_done0;
    logic [CNT_W-1:0]   r_done1;

    logic w_run;
    logic w_gnt0;
    logic w_gnt1;
    logic w_gnt_any;
    logic w_out_v;
    logic w_out_id;
    logic w_drained;

    // Grants depend only on registered state; reset low forces them off.
    assign w_run     = reset & (r_state == ST_RUN);
    assign w_gnt0    = w_run & i_req0 & (~i_req1 | ~r_ptr);
    assign w_gnt1    = w_run & i_req1 & (~i_req0 |  r_ptr);
    assign w_gnt_any = w_gnt0 | w_gnt1;

    assign w_out_v  = r_tag_v[LATENCY-1];
    assign w_out_id = r_tag_id[LATENCY-1];

    // Everything upstream of the output stage is empty: whatever sits in the
    // output stage is delivered this cycle, so the pipe is empty after the
    // edge. This lets HALT follow the last strobe by exactly one cycle.
    assign w_drained = ~|r_tag_v[LATENCY-2:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (i_stop) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!i_stop)        w_state_nxt = ST_RUN;
                else if (w_drained) w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (!i_stop) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Round-robin pointer: after any grant, the loser of this cycle gets
    // priority next time; idle cycles leave it alone.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_ptr <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipe: stage 0 loads {grant_any, granted id} every edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v  <= {r_tag_v[LATENCY-2:0],  w_gnt_any};
            r_tag_id <= {r_tag_id[LATENCY-2:0], w_gnt1};
        end
    end

    // ------------------------------------------------------------------
    // Completion counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_done0 <= '0;
            r_done1 <= '0;
        end else begin
            if (o_vld0) r_done0 <= r_done0 + CNT_W'(1);
            if (o_vld1) r_done1 <= r_done1 + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_gnt0  = w_gnt0;
    assign o_gnt1  = w_gnt1;
    assign o_add_a = w_gnt0 ? i_a0 : (w_gnt1 ? i_a1 : 4'h0);
    assign o_add_b = w_gnt0 ? i_b0 : (w_gnt1 ? i_b1 : 4'h0);
    assign o_vld0  = reset & w_out_v & ~w_out_id;
    assign o_vld1  = reset & w_out_v &  w_out_id;
    assign o_res0  = {i_add_c, i_add_sum};
    assign o_res1  = {i_add_c, i_add_sum};
    assign o_idle  = (r_state == ST_HALT);
    assign o_done0 = r_done0;
    assign o_done1 = r_done1;
    assign o_state = r_state;

endmodule

// File: tb/tb_adder_pipe_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_pipe_arbiter
//
// Drives adder_pipe_arbiter together with a behavioural 2-stage adder and
// compares every cycle against a transaction-level reference: who should be
// granted, which results are due in which cycle, the idle flag and the
// completion counts.
// ---------------------------------------------------------------------------
module tb_adder_pipe_arbiter;

    localparam int LAT   = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             stop;
    logic             req0, req1;
    logic [3:0]       a0, b0, a1, b1;
    logic             gnt0, gnt1;
    logic [3:0]       add_a, add_b;
    logic [3:0]       add_sum;
    logic             add_c;
    logic             vld0, vld1;
    logic [4:0]       res0, res1;
    logic             idle;
    logic [CNT_W-1:0] done0, done1;
    logic [1:0]       dbg_state;

    adder_pipe_arbiter #(.LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_stop    (stop),
        .i_req0    (req0),
        .i_a0      (a0),
        .i_b0      (b0),
        .o_gnt0    (gnt0),
        .i_req1    (req1),
        .i_a1      (a1),
        .i_b1      (b1),
        .o_gnt1    (gnt1),
        .o_add_a   (add_a),
        .o_add_b   (add_b),
        .i_add_sum (add_sum),
        .i_add_c   (add_c),
        .o_vld0    (vld0),
        .o_res0    (res0),
        .o_vld1    (vld1),
        .o_res1    (res1),
        .o_idle    (idle),
        .o_done0   (done0),
        .o_done1   (done1),
        .o_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural pipelined adder (shares reset) ----------------
    logic [4:0] add_s1, add_s2;
    always @(posedge clk) begin
        if (!reset) begin
            add_s1 <= 5'd0;
            add_s2 <= 5'd0;
        end else begin
            add_s1 <= {1'b0, add_a} + {1'b0, add_b};
            add_s2 <= add_s1;
        end
    end
    assign add_sum = add_s2[3:0];
    assign add_c   = add_s2[4];

    // ---------------- reference model state ----------------
    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         m_mode   = 0;     // 0 running, 1 draining, 2 halted
    bit         m_pref   = 0;     // requester that wins a tie
    int         m_done0  = 0;
    int         m_done1  = 0;
    bit         m_g0, m_g1;       // grants expected in the last cycle
    logic [5:0] exp_q[$];         // {id, result} in grant order
    int         due_q[$];         // cycle each result is due

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at the negedge, advance the model,
    // then step past the posedge so the caller can set the next inputs.
    task automatic cycle();
        bit         e0, e1, v0, v1;
        logic [4:0] ev;
        logic [5:0] ent;
        @(negedge clk);
        e0 = 0; e1 = 0;
        if (reset && m_mode == 0) begin
            if (req0 && req1) begin
                e0 = !m_pref;
                e1 = m_pref;
            end else begin
                e0 = req0;
                e1 = req1;
            end
        end
        chk("gnt0", gnt0, e0);
        chk("gnt1", gnt1, e1);
        if (e0) begin
            chk("add_a", add_a, a0);
            chk("add_b", add_b, b0);
        end else if (e1) begin
            chk("add_a", add_a, a1);
            chk("add_b", add_b, b1);
        end else begin
            chk("add_a_zero", add_a, 4'h0);
            chk("add_b_zero", add_b, 4'h0);
        end

        v0 = 0; v1 = 0; ev = '0;
        if (reset && due_q.size() > 0 && due_q[0] == cyc) begin
            ent = exp_q.pop_front();
            void'(due_q.pop_front());
            ev  = ent[4:0];
            if (ent[5]) v1 = 1; else v0 = 1;
        end
        chk("vld0", vld0, v0);
        chk("vld1", vld1, v1);
        if (v0) chk("res0", res0, ev);
        if (v1) chk("res1", res1, ev);
        chk("idle", idle, (m_mode == 2));
        chk("done0", done0, m_done0);
        chk("done1", done1, m_done1);

        if (v0) m_done0 = (m_done0 + 1) % (1 << CNT_W);
        if (v1) m_done1 = (m_done1 + 1) % (1 << CNT_W);

        if (!reset) begin
            m_mode  = 0;
            m_pref  = 0;
            m_done0 = 0;
            m_done1 = 0;
            exp_q.delete();
            due_q.delete();
        end else begin
            if (e0) begin
                exp_q.push_back({1'b0, 5'(a0 + b0)});
                due_q.push_back(cyc + LAT);
                m_pref = 1;
            end else if (e1) begin
                exp_q.push_back({1'b1, 5'(a1 + b1)});
                due_q.push_back(cyc + LAT);
                m_pref = 0;
            end
            case (m_mode)
                0: if (stop) m_mode = 1;
                1: if (!stop) m_mode = 0; else if (exp_q.size() == 0) m_mode = 2;
                default: if (!stop) m_mode = 0;
            endcase
        end
        m_g0 = e0;
        m_g1 = e1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Requesters hold until granted; a granted or idle requester draws anew.
    task automatic refresh(input int pct);
        if (!req0 || m_g0) begin
            req0 = ($urandom_range(0, 99) < pct);
            a0   = 4'($urandom);
            b0   = 4'($urandom);
        end
        if (!req1 || m_g1) begin
            req1 = ($urandom_range(0, 99) < pct);
            a1   = 4'($urandom);
            b1   = 4'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        req0 = 0; req1 = 0; stop = 0;
        repeat (n) cycle();
        reset = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1'b0; stop = 0;
        req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        m_g0 = 0; m_g1 = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        do_reset(2);
        cycle();

        // Single requester: 9 + 8 -> 5'h11 two cycles after the grant
        req0 = 1; a0 = 4'h9; b0 = 4'h8;
        cycle();
        req0 = 0;
        repeat (3) cycle();
        chk("t1_done0", done0, 8'd1);
        chk("t1_done1", done1, 8'd0);

        // Continuous contention: strict alternation, 3 results each
        do_reset(1);
        req0 = 1; req1 = 1;
        for (int i = 0; i < 6; i++) begin
            a0 = 4'($urandom); b0 = 4'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom);
            cycle();
        end
        req0 = 0; req1 = 0;
        repeat (3) cycle();
        chk("t2_done0", done0, 8'd3);
        chk("t2_done1", done1, 8'd3);

        // Stop with operations in flight, then resume
        do_reset(1);
        req0 = 0; req1 = 0;
        refresh(100);
        cycle();
        refresh(100);
        cycle();
        stop = 1;
        for (int i = 0; i < 6; i++) begin
            refresh(100);
            cycle();
        end
        chk("t3_idle", idle, 1'b1);
        stop = 0;
        for (int i = 0; i < 5; i++) begin
            refresh(100);
            cycle();
        end
        req0 = 0; req1 = 0;
        repeat (3) cycle();

        // Reset one cycle after a grant: that result never appears
        do_reset(1);
        req0 = 1; a0 = 4'h3; b0 = 4'h4;
        cycle();
        req0 = 0;
        do_reset(1);
        req0 = 1; req1 = 1;
        cycle();
        req0 = 0; req1 = 0;
        repeat (3) cycle();
        chk("t4_done0", done0, 8'd1);
        chk("t4_done1", done1, 8'd0);

        // 256 back-to-back ops, 15 + 1 -> 5'h10, counter wraps to 0
        do_reset(1);
        req0 = 1; a0 = 4'hF; b0 = 4'h1;
        repeat (256) cycle();
        req0 = 0;
        repeat (3) cycle();
        chk("t5_done0_wrap", done0, 8'h00);

        // Random traffic with occasional stop toggles and resets
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            refresh(60);
            if ($urandom_range(0, 15) == 0) stop = ~stop;
            reset = ($urandom_range(0, 99) != 0);
            cycle();
        end
        reset = 1; stop = 0; req0 = 0; req1 = 0;
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
